mips_main_control: RTL and testbench

Multicycle main control FSM for the MIPS datapath. It decodes the instruction-register opcode and funct fields and drives every mux select and register-enable in the datapath, one state per clock. It also sequences the reset stack-pointer initialisation and the overflow and invalid-opcode exception entry. Supported instruction subset: R-type add/sub/and/jr, addi, lw, sw, beq, bne, j.

---
 rtl/mips_main_control.sv | 202 ++++++++++++++++++++
 tb/tb_mips_main_control.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mips_main_control.sv
// mips_main_control -- multicycle main control FSM for the MIPS datapath.
//
// Decodes IR opcode/funct and drives every datapath mux select and register
// enable, one state per clock. Also sequences the reset $29 initialisation
// and the overflow / invalid-opcode exception entry.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode, funct       IR[31:26], IR[5:0]
//   zero, overflow      ALU flags
//   pcWrite .. epcControl  register/memory enables
//   iord, excpControl, aluSrcA, aluSrcB, aluControl, srcWrite, srcData,
//   pcSource, lsControl    datapath mux selects
//   state_dbg           current state encoding (verification visibility)
module mips_main_control #(
    parameter int          MEM_WAIT = 2,
    parameter int unsigned SP_INIT  = 227
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       memWrite,
    output logic       regWrite,
    output logic       memRegControl,
    output logic       aControl,
    output logic       bControl,
    output logic       aluOutControl,
    output logic       epcControl,
    output logic [1:0] iord,
    output logic [1:0] excpControl,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluControl,
    output logic [2:0] srcWrite,
    output logic [3:0] srcData,
    output logic [2:0] pcSource,
    output logic [1:0] lsControl,
    output logic [4:0] state_dbg
);
    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_FWAIT, S_FIR, S_DECODE,
        S_R_EX, S_R_WB, S_ADDI_EX, S_I_WB,
        S_ADDR, S_SW_WR, S_LW_RD, S_LW_WAIT, S_LW_MDR, S_LW_WB,
        S_BR, S_JMP, S_JR,
        S_EXC_EPC, S_EXC_WAIT, S_EXC_MDR, S_EXC_PC
    } state_t;

    // One shared counter paces every memory wait; it restarts whenever the
    // FSM enters a wait state from a different state.
    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

    // The $29 reset value itself is a datapath constant; it only has to fit
    // the 8-bit constant path selected by srcData=1000.
    if (SP_INIT > 32'd255) begin : g_sp_init_out_of_range
    end

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [1:0]      cause, cause_next;
    logic            wait_done;
    logic            is_r_alu, is_jr, add_sub;

    assign wait_done = (cnt == WAIT_LAST);
    assign is_r_alu  = (opcode == 6'h00) &&
                       (funct == 6'h20 || funct == 6'h22 || funct == 6'h24);
    assign is_jr     = (opcode == 6'h00) && (funct == 6'h08);
    assign add_sub   = (funct == 6'h20) || (funct == 6'h22);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RST;
            cnt   <= '0;
            cause <= 2'b00;
        end else begin
            state <= state_next;
            cause <= cause_next;
            if (state_next == state) cnt <= cnt + 1'b1;
            else                     cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        cause_next = cause;
        unique case (state)
            S_RST:     state_next = S_FETCH;
            S_FETCH:   state_next = (MEM_WAIT == 0) ? S_FIR : S_FWAIT;
            S_FWAIT:   if (wait_done) state_next = S_FIR;
            S_FIR:     state_next = S_DECODE;
            S_DECODE: begin
                if (is_r_alu)                                  state_next = S_R_EX;
                else if (is_jr)                                state_next = S_JR;
                else if (opcode == 6'h08)                      state_next = S_ADDI_EX;
                else if (opcode == 6'h23 || opcode == 6'h2B)   state_next = S_ADDR;
                else if (opcode == 6'h04 || opcode == 6'h05)   state_next = S_BR;
                else if (opcode == 6'h02)                      state_next = S_JMP;
                else begin
                    state_next = S_EXC_EPC;
                    cause_next = 2'b00;
                end
            end
            S_R_EX: begin
                if (add_sub && overflow) begin
                    state_next = S_EXC_EPC;
                    cause_next = 2'b01;
                end else state_next = S_R_WB;
            end
            S_ADDI_EX: begin
                if (overflow) begin
                    state_next = S_EXC_EPC;
                    cause_next = 2'b01;
                end else state_next = S_I_WB;
            end
            S_ADDR:     state_next = (opcode == 6'h23) ? S_LW_RD : S_SW_WR;
            S_LW_RD:    state_next = (MEM_WAIT == 0) ? S_LW_MDR : S_LW_WAIT;
            S_LW_WAIT:  if (wait_done) state_next = S_LW_MDR;
            S_LW_MDR:   state_next = S_LW_WB;
            S_EXC_EPC:  state_next = (MEM_WAIT == 0) ? S_EXC_MDR : S_EXC_WAIT;
            S_EXC_WAIT: if (wait_done) state_next = S_EXC_MDR;
            S_EXC_MDR:  state_next = S_EXC_PC;
            S_R_WB, S_I_WB, S_SW_WR, S_LW_WB, S_BR, S_JMP, S_JR, S_EXC_PC:
                        state_next = S_FETCH;
            default:    state_next = S_RST;
        endcase
    end

    // Moore outputs (BR's pcWrite additionally follows zero)
    always_comb begin
        pcWrite = 1'b0; irWrite = 1'b0; memWrite = 1'b0; regWrite = 1'b0;
        memRegControl = 1'b0; aControl = 1'b0; bControl = 1'b0;
        aluOutControl = 1'b0; epcControl = 1'b0;
        iord = 2'b00; excpControl = 2'b00; aluSrcA = 2'b00; aluSrcB = 2'b00;
        aluControl = 3'b000; srcWrite = 3'b000; srcData = 4'b0000;
        pcSource = 3'b000; lsControl = 2'b00;
        unique case (state)
            S_RST: begin
                regWrite = 1'b1; srcWrite = 3'b010; srcData = 4'b1000;
            end
            S_FIR: begin
                irWrite = 1'b1; aluSrcB = 2'b01; aluControl = 3'b001; pcWrite = 1'b1;
            end
            S_DECODE: begin
                aControl = 1'b1; bControl = 1'b1; aluSrcB = 2'b11;
                aluControl = 3'b001; aluOutControl = 1'b1;
            end
            S_R_EX: begin
                aluSrcA = 2'b01; aluOutControl = 1'b1;
                aluControl = (funct == 6'h22) ? 3'b010 :
                             (funct == 6'h24) ? 3'b011 : 3'b001;
            end
            S_R_WB: begin
                regWrite = 1'b1; srcWrite = 3'b001; srcData = 4'b1001;
            end
            S_ADDI_EX, S_ADDR: begin
                aluSrcA = 2'b01; aluSrcB = 2'b10; aluControl = 3'b001; aluOutControl = 1'b1;
            end
            S_I_WB: begin
                regWrite = 1'b1; srcData = 4'b1001;
            end
            S_SW_WR: begin
                iord = 2'b01; memWrite = 1'b1;
            end
            S_LW_RD, S_LW_WAIT: iord = 2'b01;
            S_LW_MDR:           memRegControl = 1'b1;
            S_LW_WB: begin
                srcData = 4'b0001; regWrite = 1'b1;
            end
            S_BR: begin
                aluSrcA = 2'b01; aluControl = 3'b010; pcSource = 3'b001;
                pcWrite = (opcode == 6'h04) ? zero : ~zero;
            end
            S_JMP: begin
                pcSource = 3'b010; pcWrite = 1'b1;
            end
            S_JR: begin
                pcSource = 3'b011; pcWrite = 1'b1;
            end
            S_EXC_EPC: begin
                aluSrcB = 2'b01; aluControl = 3'b010; epcControl = 1'b1;
                iord = 2'b10; excpControl = cause;
            end
            S_EXC_WAIT: begin
                iord = 2'b10; excpControl = cause;
            end
            S_EXC_MDR: begin
                memRegControl = 1'b1; iord = 2'b10; excpControl = cause;
            end
            S_EXC_PC: begin
                lsControl = 2'b10; pcSource = 3'b101; pcWrite = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control. An instruction-level model
// expands each instruction into the per-cycle output vectors it should
// produce; the DUT outputs are compared against that list every cycle.
module tb_mips_main_control;
    localparam int MW = 2;

    logic       clk = 1'b0, reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, overflow = 1'b0;
    logic       pcWrite, irWrite, memWrite, regWrite, memRegControl;
    logic       aControl, bControl, aluOutControl, epcControl;
    logic [1:0] iord, excpControl, aluSrcA, aluSrcB, lsControl;
    logic [2:0] aluControl, srcWrite, pcSource;
    logic [3:0] srcData;
    logic [4:0] state_dbg;

    mips_main_control #(.MEM_WAIT(MW), .SP_INIT(227)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow),
        .pcWrite(pcWrite), .irWrite(irWrite), .memWrite(memWrite),
        .regWrite(regWrite), .memRegControl(memRegControl),
        .aControl(aControl), .bControl(bControl),
        .aluOutControl(aluOutControl), .epcControl(epcControl),
        .iord(iord), .excpControl(excpControl), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluControl(aluControl), .srcWrite(srcWrite),
        .srcData(srcData), .pcSource(pcSource), .lsControl(lsControl),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_w, ir_w, mem_w, reg_w, mdr_w, a_w, b_w, aluout_w, epc_w;
        logic [1:0] iord, excp, src_a, src_b;
        logic [2:0] alu, src_write;
        logic [3:0] src_data;
        logic [2:0] pc_src;
        logic [1:0] ls;
    } outs_t;

    outs_t act;
    assign act = {pcWrite, irWrite, memWrite, regWrite, memRegControl,
                  aControl, bControl, aluOutControl, epcControl,
                  iord, excpControl, aluSrcA, aluSrcB, aluControl,
                  srcWrite, srcData, pcSource, lsControl};

    outs_t exp_q[$];
    int checks = 0, errors = 0;

    function automatic outs_t rst_o();
        outs_t o = '0;
        o.reg_w = 1'b1; o.src_write = 3'b010; o.src_data = 4'b1000;
        return o;
    endfunction

    task automatic check_cycle(input string tag, input outs_t e);
        @(posedge clk); #1;
        checks++;
        assert (act === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, act, e);
        end
        checks++;
        assert (!$isunknown(state_dbg)) else begin
            errors++;
            $error("FAIL %s state_dbg: got %h expected known value", tag, state_dbg);
        end
    endtask

    task automatic push_exc(input logic [1:0] c);
        outs_t o = '0;
        o.src_b = 2'b01; o.alu = 3'b010; o.epc_w = 1'b1; o.iord = 2'b10; o.excp = c;
        exp_q.push_back(o);
        o = '0; o.iord = 2'b10; o.excp = c;
        repeat (MW) exp_q.push_back(o);
        o.mdr_w = 1'b1;
        exp_q.push_back(o);
        o = '0; o.ls = 2'b10; o.pc_src = 3'b101; o.pc_w = 1'b1;
        exp_q.push_back(o);
    endtask

    // Expand one instruction into its expected per-cycle outputs.
    task automatic build(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic ov);
        outs_t o;
        exp_q.delete();
        o = '0;
        repeat (MW + 1) exp_q.push_back(o);               // fetch + memory wait
        o.ir_w = 1'b1; o.src_b = 2'b01; o.alu = 3'b001; o.pc_w = 1'b1;
        exp_q.push_back(o);
        o = '0; o.a_w = 1'b1; o.b_w = 1'b1; o.src_b = 2'b11; o.alu = 3'b001; o.aluout_w = 1'b1;
        exp_q.push_back(o);
        o = '0;
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            o.src_a = 2'b01; o.aluout_w = 1'b1;
            o.alu = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            exp_q.push_back(o);
            if (fn != 6'h24 && ov) push_exc(2'b01);
            else begin
                o = '0; o.reg_w = 1'b1; o.src_write = 3'b001; o.src_data = 4'b1001;
                exp_q.push_back(o);
            end
        end else if (op == 6'h00 && fn == 6'h08) begin
            o.pc_src = 3'b011; o.pc_w = 1'b1;
            exp_q.push_back(o);
        end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
            o.src_a = 2'b01; o.src_b = 2'b10; o.alu = 3'b001; o.aluout_w = 1'b1;
            exp_q.push_back(o);
            o = '0;
            if (op == 6'h08) begin
                if (ov) push_exc(2'b01);
                else begin
                    o.reg_w = 1'b1; o.src_data = 4'b1001;
                    exp_q.push_back(o);
                end
            end else if (op == 6'h2B) begin
                o.iord = 2'b01; o.mem_w = 1'b1;
                exp_q.push_back(o);
            end else begin
                o.iord = 2'b01;
                repeat (MW + 1) exp_q.push_back(o);
                o = '0; o.mdr_w = 1'b1;
                exp_q.push_back(o);
                o = '0; o.src_data = 4'b0001; o.reg_w = 1'b1;
                exp_q.push_back(o);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            o.src_a = 2'b01; o.alu = 3'b010; o.pc_src = 3'b001;
            o.pc_w = (op == 6'h04) ? z : !z;
            exp_q.push_back(o);
        end else if (op == 6'h02) begin
            o.pc_src = 3'b010; o.pc_w = 1'b1;
            exp_q.push_back(o);
        end else begin
            push_exc(2'b00);
        end
    endtask

    // abort_at >= 0 raises reset after that cycle of the instruction.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic ov, input int abort_at);
        opcode = op; funct = fn; zero = z; overflow = ov;
        build(op, fn, z, ov);
        for (int i = 0; i < exp_q.size(); i++) begin
            check_cycle($sformatf("%s[%0d]", name, i), exp_q[i]);
            if (i == abort_at) begin
                reset = 1'b1;
                check_cycle({name, "_reset"}, rst_o());
                reset = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        logic [5:0] ops [8];
        logic [5:0] fns [5];
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h21};

        repeat (3) check_cycle("reset", rst_o());
        reset = 1'b0;

        run_instr("add",        6'h00, 6'h20, 1'b0, 1'b0, -1);
        run_instr("addi_ovf",   6'h08, 6'h00, 1'b0, 1'b1, -1);
        run_instr("beq_nz",     6'h04, 6'h00, 1'b0, 1'b0, -1);
        run_instr("beq_z",      6'h04, 6'h00, 1'b1, 1'b0, -1);
        run_instr("bne_nz",     6'h05, 6'h00, 1'b0, 1'b0, -1);
        run_instr("bne_z",      6'h05, 6'h00, 1'b1, 1'b0, -1);
        run_instr("bad_op",     6'h3F, 6'h00, 1'b0, 1'b0, -1);
        run_instr("lw",         6'h23, 6'h00, 1'b0, 1'b1, -1);
        run_instr("lw_abort",   6'h23, 6'h00, 1'b0, 1'b0, MW + 4);
        run_instr("sub_ovf",    6'h00, 6'h22, 1'b0, 1'b1, -1);
        run_instr("and_ovf",    6'h00, 6'h24, 1'b0, 1'b1, -1);
        run_instr("bad_funct",  6'h00, 6'h25, 1'b0, 1'b0, -1);
        run_instr("jr",         6'h00, 6'h08, 1'b0, 1'b0, -1);
        run_instr("j",          6'h02, 6'h00, 1'b1, 1'b0, -1);
        run_instr("sw",         6'h2B, 6'h00, 1'b0, 1'b1, -1);
        run_instr("addi",       6'h08, 6'h00, 1'b1, 1'b0, -1);

        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr($sformatf("rnd%0d_op%h_fn%h", n, op, fn), op, fn,
                      1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0) ? 3 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
